// File: rtl/counter_pkg.sv
// Shared types and defaults for the prescaled counter family: command encoding,
// default sizing and the load/inc/dec priority decode.
package counter_pkg;

  localparam int DEFAULT_WIDTH    = 4;
  localparam int DEFAULT_PRESCALE = 1200001;

  typedef enum logic [1:0] {
    CMD_HOLD = 2'd0,
    CMD_LOAD = 2'd1,
    CMD_INC  = 2'd2,
    CMD_DEC  = 2'd3
  } cmd_e;

  // load dominates; inc and dec cancel each other out when both are set
  function automatic cmd_e decode_cmd(input logic load, input logic inc, input logic dec);
    if (load)
      return CMD_LOAD;
    if (inc && !dec)
      return CMD_INC;
    if (dec && !inc)
      return CMD_DEC;
    return CMD_HOLD;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler producing a registered one-clock tick every PRESCALE clocks.
// Reusable by any slow-rate block; reset realigns the tick phase to reset release.
module tick_gen
  import counter_pkg::*;
#(
  parameter int PRESCALE = DEFAULT_PRESCALE
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int PS_W = $clog2(PRESCALE + 1);
  localparam logic [PS_W-1:0] LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] prescaler;

  // tick is raised on the wrap edge, so the first pulse lands PRESCALE clocks after reset
  always_ff @(posedge clock) begin
    if (reset) begin
      prescaler <= '0;
      tick      <= 1'b0;
    end else if (prescaler == LAST) begin
      prescaler <= '0;
      tick      <= 1'b1;
    end else begin
      prescaler <= prescaler + PS_W'(1);
      tick      <= 1'b0;
    end
  end

endmodule

// File: rtl/prescaled_counter.sv
// Up/down/load counter advanced once per prescaler tick, with terminal flag and heartbeat.
// Define PRESCALED_COUNTER_SATURATE_EN to clamp at max/zero instead of wrapping.
module prescaled_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int PRESCALE = DEFAULT_PRESCALE
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             inc,
  input  logic             dec,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             terminal,
  output logic             heartbeat
);

  localparam logic [WIDTH-1:0] MAX = '1;

  cmd_e cmd;
  logic at_max;
  logic at_zero;

  tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick_gen (
    .clock(clock),
    .reset(reset),
    .tick (tick)
  );

  assign cmd     = decode_cmd(load, inc, dec);
  assign at_max  = (count == MAX);
  assign at_zero = (count == '0);

  always_comb begin
    terminal = 1'b0;
    if ((cmd == CMD_INC && at_max) || (cmd == CMD_DEC && at_zero))
      terminal = 1'b1;
  end

  // commands are level-sampled only on tick edges; count holds in between
  always_ff @(posedge clock) begin
    if (reset) begin
      count     <= '0;
      heartbeat <= 1'b0;
    end else if (tick) begin
      heartbeat <= ~heartbeat;
      case (cmd)
        CMD_LOAD: count <= in;
`ifdef PRESCALED_COUNTER_SATURATE_EN
        CMD_INC:  count <= at_max  ? count : count + WIDTH'(1);
        CMD_DEC:  count <= at_zero ? count : count - WIDTH'(1);
`else
        CMD_INC:  count <= count + WIDTH'(1);
        CMD_DEC:  count <= count - WIDTH'(1);
`endif
        default:  count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_prescaled_counter.sv
// Directed self-checking bench for prescaled_counter (WIDTH=4, PRESCALE=4 and PRESCALE=1).
// Saturating expectations are selected with PRESCALED_COUNTER_SATURATE_EN.
module tb_prescaled_counter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       load  = 1'b0;
  logic       inc   = 1'b0;
  logic       dec   = 1'b0;
  logic [3:0] in    = 4'd0;
  logic [3:0] count;
  logic       tick;
  logic       terminal;
  logic       heartbeat;

  logic       reset1 = 1'b1;
  logic       inc1   = 1'b0;
  logic [3:0] count1;
  logic       tick1;
  logic       terminal1;
  logic       heartbeat1;

  int         tests_run = 0;
  int         failed    = 0;
  logic [3:0] exp_count = 4'd0;

  always #5 clock = ~clock;

  prescaled_counter #(.WIDTH(4), .PRESCALE(4)) dut (
    .clock(clock), .reset(reset), .load(load), .inc(inc), .dec(dec), .in(in),
    .count(count), .tick(tick), .terminal(terminal), .heartbeat(heartbeat)
  );

  prescaled_counter #(.WIDTH(4), .PRESCALE(1)) dut1 (
    .clock(clock), .reset(reset1), .load(1'b0), .inc(inc1), .dec(1'b0), .in(4'd0),
    .count(count1), .tick(tick1), .terminal(terminal1), .heartbeat(heartbeat1)
  );

  function automatic logic [3:0] model_inc(input logic [3:0] v);
`ifdef PRESCALED_COUNTER_SATURATE_EN
    return (v == 4'hF) ? v : v + 4'd1;
`else
    return v + 4'd1;
`endif
  endfunction

  function automatic logic [3:0] model_dec(input logic [3:0] v);
`ifdef PRESCALED_COUNTER_SATURATE_EN
    return (v == 4'h0) ? v : v - 4'd1;
`else
    return v - 4'd1;
`endif
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // advance to the next tick cycle, then through the edge that applies the commands
  task automatic do_tick();
    int n = 0;
    while (tick !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    if (tick !== 1'b1) begin
      tests_run++;
      failed++;
      $display("[TB] FAIL tick_timeout: tick=%b required 1", tick);
    end
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    tests_run++;
    if (count !== 4'd0 || heartbeat !== 1'b0 || tick !== 1'b0) begin
      failed++;
      $display("[TB] FAIL reset_state: count=%0d hb=%b tick=%b required 0 0 0", count, heartbeat, tick);
    end
    reset = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      tests_run++;
      if (tick !== ((k % 4) == 0)) begin
        failed++;
        $display("[TB] FAIL tick_timing k=%0d: tick=%b required %b", k, tick, (k % 4) == 0);
      end
      tests_run++;
      if (heartbeat !== (((k - 1) / 4) % 2 == 1)) begin
        failed++;
        $display("[TB] FAIL heartbeat k=%0d: hb=%b required %b", k, heartbeat, ((k - 1) / 4) % 2 == 1);
      end
    end
    tests_run++;
    if (count !== 4'd0 || terminal !== 1'b0) begin
      failed++;
      $display("[TB] FAIL idle_hold: count=%0d terminal=%b required 0 0", count, terminal);
    end
    exp_count = 4'd0;
  endtask

  task automatic test_up_wrap();
    inc = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      do_tick();
      exp_count = model_inc(exp_count);
      tests_run++;
      if (count !== exp_count) begin
        failed++;
        $display("[TB] FAIL up_count i=%0d: count=%0d required %0d", i, count, exp_count);
      end
      tests_run++;
      if (terminal !== (exp_count == 4'hF)) begin
        failed++;
        $display("[TB] FAIL up_terminal i=%0d: terminal=%b required %b", i, terminal, exp_count == 4'hF);
      end
    end
    inc = 1'b0;
  endtask

  task automatic test_load_priority();
    in   = 4'd9;
    load = 1'b1;
    inc  = 1'b1;
    do_tick();
    load = 1'b0;
    inc  = 1'b0;
    exp_count = 4'd9;
    tests_run++;
    if (count !== 4'd9) begin
      failed++;
      $display("[TB] FAIL load_priority: count=%0d required 9", count);
    end
    dec = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      do_tick();
      exp_count = model_dec(exp_count);
      tests_run++;
      if (count !== exp_count) begin
        failed++;
        $display("[TB] FAIL down_count i=%0d: count=%0d required %0d", i, count, exp_count);
      end
      tests_run++;
      if (terminal !== (exp_count == 4'h0)) begin
        failed++;
        $display("[TB] FAIL down_terminal i=%0d: terminal=%b required %b", i, terminal, exp_count == 4'h0);
      end
    end
    inc = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      do_tick();
      tests_run++;
      if (count !== exp_count) begin
        failed++;
        $display("[TB] FAIL inc_dec_hold i=%0d: count=%0d required %0d", i, count, exp_count);
      end
    end
    inc = 1'b0;
    dec = 1'b0;
  endtask

  task automatic test_off_tick();
    do_tick();
    in   = 4'd5;
    load = 1'b1;
    step();
    load = 1'b0;
    tests_run++;
    if (count !== exp_count) begin
      failed++;
      $display("[TB] FAIL off_tick_load: count=%0d required %0d", count, exp_count);
    end
    do_tick();
    tests_run++;
    if (count !== exp_count) begin
      failed++;
      $display("[TB] FAIL off_tick_next: count=%0d required %0d", count, exp_count);
    end
  endtask

  task automatic test_reset_mid();
    in   = 4'd7;
    load = 1'b1;
    do_tick();
    load = 1'b0;
    tests_run++;
    if (count !== 4'd7) begin
      failed++;
      $display("[TB] FAIL mid_preload: count=%0d required 7", count);
    end
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_count = 4'd0;
    tests_run++;
    if (count !== 4'd0 || tick !== 1'b0 || heartbeat !== 1'b0) begin
      failed++;
      $display("[TB] FAIL mid_reset: count=%0d tick=%b hb=%b required 0 0 0", count, tick, heartbeat);
    end
    for (int k = 1; k <= 4; k++) begin
      step();
      tests_run++;
      if (tick !== (k == 4)) begin
        failed++;
        $display("[TB] FAIL mid_realign k=%0d: tick=%b required %b", k, tick, k == 4);
      end
    end
  endtask

  task automatic test_prescale_one();
    reset1 = 1'b1;
    step();
    tests_run++;
    if (count1 !== 4'd0 || tick1 !== 1'b0) begin
      failed++;
      $display("[TB] FAIL ps1_reset: count=%0d tick=%b required 0 0", count1, tick1);
    end
    reset1 = 1'b0;
    inc1   = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      tests_run++;
      if (tick1 !== 1'b1 || count1 !== 4'(k - 1)) begin
        failed++;
        $display("[TB] FAIL ps1_run k=%0d: tick=%b count=%0d required 1 %0d", k, tick1, count1, k - 1);
      end
    end
    inc1 = 1'b0;
  endtask

`ifdef PRESCALED_COUNTER_SATURATE_EN
  task automatic test_saturate();
    in   = 4'd15;
    load = 1'b1;
    do_tick();
    load = 1'b0;
    inc  = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      do_tick();
      tests_run++;
      if (count !== 4'd15 || terminal !== 1'b1) begin
        failed++;
        $display("[TB] FAIL sat_max i=%0d: count=%0d terminal=%b required 15 1", i, count, terminal);
      end
    end
    inc  = 1'b0;
    in   = 4'd0;
    load = 1'b1;
    do_tick();
    load = 1'b0;
    dec  = 1'b1;
    do_tick();
    tests_run++;
    if (count !== 4'd0 || terminal !== 1'b1) begin
      failed++;
      $display("[TB] FAIL sat_zero: count=%0d terminal=%b required 0 1", count, terminal);
    end
    dec = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_up_wrap();
    test_load_priority();
    test_off_tick();
    test_reset_mid();
    test_prescale_one();
`ifdef PRESCALED_COUNTER_SATURATE_EN
    test_saturate();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
